// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
//   state_e      : transmitter FSM states
//   ERR_*        : err_code encodings
//   *_BIT_IDX    : bit counter values for parity and stop positions
//   odd_parity() : parity bit that makes the 9-bit frame odd
package ps2_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SEND,
    ACK,
    WAIT_IDLE
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK   = 2'b10;

  localparam logic [3:0] PARITY_BIT_IDX = 4'd9;
  localparam logic [3:0] STOP_BIT_IDX   = 4'd10;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Host-side request/status bundle of the PS/2 transmitter.
//   tx_data/tx_start : byte and one-cycle start request (from host logic)
//   busy             : transfer in progress (paired receiver ignores bus)
//   tx_done/tx_err   : one-cycle completion pulses
//   err_code         : last failure reason, held until next accepted start
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] err_code;

  modport master (output tx_data, tx_start, input busy, tx_done, tx_err, err_code);
  modport slave  (input tx_data, tx_start, output busy, tx_done, tx_err, err_code);
endinterface

// File: rtl/ps2_host_tx_line_filter.sv
// ps2_line_filter: 2-FF synchronizer followed by a stable-sample glitch
// filter for one open-collector PS/2 line. Resets to 1 (idle line).
//   clk, rst_n : system clock, async active-low reset
//   pad_in     : raw pad value
//   filt       : filtered value; changes only after FILTER_LEN consecutive
//                synchronized samples disagree with it
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_in,
  output logic filt
);

  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic [1:0]    sync_q, sync_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], pad_in};
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte host-to-device over PS/2 and checks
// the device ACK. Lines are open-collector: an _oe of 1 pulls the line low.
//   clk, rst_n            : system clock, async active-low reset
//   ps2clk_in, ps2data_in : raw pad values
//   ps2clk_oe, ps2data_oe : 1 = drive the line low
//   host                  : request/status bundle (ps2_host_tx_if.slave)
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | lines released, waiting for tx_start
// INHIBIT   | clock held low INHIBIT_CYC cycles
// START     | clock released, data low (start bit)
// SEND      | on each device clock fall, present data/parity/stop
// ACK       | sample device ACK on next clock fall
// WAIT_IDLE | wait for both lines high, then report result
module ps2_host_tx
  import ps2_host_pkg::*;
#(
  parameter int INHIBIT_CYC = 3500,
  parameter int TIMEOUT_CYC = 560000,
  parameter int FILTER_LEN  = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ps2clk_in,
  input  logic         ps2data_in,
  output logic         ps2clk_oe,
  output logic         ps2data_oe,
  ps2_host_tx_if.slave host
);

  localparam int INH_W = $clog2(INHIBIT_CYC) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC) + 1;

  state_e             state_q, state_d;
  logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [3:0]         bitcnt_q, bitcnt_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               parity_q, parity_d;
  logic               ack_ok_q, ack_ok_d;
  logic               clk_oe_q, clk_oe_d;
  logic               data_oe_q, data_oe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               clk_prev_q, clk_prev_d;

  logic               clk_filt, data_filt, fall;
  logic               to_run, to_hit;
  logic [3:0]         next_bit;
  logic [2:0]         bit_idx;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst_n(rst_n), .pad_in(ps2clk_in), .filt(clk_filt)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk), .rst_n(rst_n), .pad_in(ps2data_in), .filt(data_filt)
  );

  assign clk_prev_d = clk_filt;
  assign fall       = clk_prev_q & ~clk_filt;

  always_comb begin
    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    parity_d   = parity_q;
    ack_ok_d   = ack_ok_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    next_bit   = '0;
    bit_idx    = '0;

    to_run = (state_q == START) || (state_q == SEND) ||
             (state_q == ACK)   || (state_q == WAIT_IDLE);
    to_hit = to_run && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
    if (to_run && (to_cnt_q != TO_W'(TIMEOUT_CYC))) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    // Timeout wins over any clock fall seen in the same cycle.
    if (to_hit) begin
      state_d    = IDLE;
      clk_oe_d   = 1'b0;
      data_oe_d  = 1'b0;
      err_code_d = ERR_TIMEOUT;
      err_d      = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          if (host.tx_start) begin
            shreg_d    = host.tx_data;
            parity_d   = odd_parity(host.tx_data);
            err_code_d = ERR_NONE;
            inh_cnt_d  = '0;
            clk_oe_d   = 1'b1;
            state_d    = INHIBIT;
          end
        end
        INHIBIT: begin
          clk_oe_d = 1'b1;
          if (inh_cnt_q == INH_W'(INHIBIT_CYC - 1)) begin
            // Counters are cleared on entry so START is already the
            // first counted timeout cycle.
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b1;
            bitcnt_d  = '0;
            to_cnt_d  = '0;
            state_d   = START;
          end else begin
            inh_cnt_d = inh_cnt_q + 1'b1;
          end
        end
        START: state_d = SEND;
        SEND: begin
          if (fall) begin
            next_bit = bitcnt_q + 4'd1;
            bitcnt_d = next_bit;
            if (next_bit == STOP_BIT_IDX) begin
              data_oe_d = 1'b0;
              state_d   = ACK;
            end else if (next_bit == PARITY_BIT_IDX) begin
              data_oe_d = ~parity_q;
            end else begin
              bit_idx   = 3'(next_bit - 4'd1);
              data_oe_d = ~shreg_q[bit_idx];
            end
          end
        end
        ACK: begin
          if (fall) begin
            ack_ok_d = ~data_filt;
            state_d  = WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          // Result is reported only once the device has released the bus.
          if (clk_filt && data_filt) begin
            state_d = IDLE;
            if (ack_ok_q) begin
              done_d = 1'b1;
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_NOACK;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      ack_ok_q   <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      ack_ok_q   <= ack_ok_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  assign ps2clk_oe     = clk_oe_q;
  assign ps2data_oe    = data_oe_q;
  assign host.busy     = busy_q;
  assign host.tx_done  = done_q;
  assign host.tx_err   = err_q;
  assign host.err_code = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model.
// Timeout and device clock period are scaled down to keep runtime short.
module tb_ps2_host_tx;

  localparam int INH  = 3500;
  localparam int TO   = 4000;
  localparam int FLT  = 8;
  localparam int HALF = 40;
  localparam int BOUND = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2clk_oe, ps2data_oe;
  logic ps2clk_in, ps2data_in;

  assign ps2clk_in  = ~ps2clk_oe & ~dev_clk_low;
  assign ps2data_in = ~ps2data_oe & ~dev_data_low;

  ps2_host_tx_if host_if ();

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .FILTER_LEN(FLT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ps2clk_in(ps2clk_in), .ps2data_in(ps2data_in),
    .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe),
    .host(host_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int inh_run = 0, last_inh = 0, start_cyc = 0;
  logic data_prev = 1'b0, clk_oe_prev = 1'b0;
  always @(negedge clk) begin
    if (host_if.tx_done) done_cnt++;
    if (host_if.tx_err) err_cnt++;
    if (host_if.tx_done && host_if.tx_err) both_cnt++;
    if (ps2clk_oe) inh_run++;
    else if (inh_run != 0) begin
      last_inh = inh_run;
      inh_run = 0;
    end
    if (ps2data_oe && !data_prev && clk_oe_prev) start_cyc = cyc;
    data_prev = ps2data_oe;
    clk_oe_prev = ps2clk_oe;
  end

  logic       busy_after_start;
  logic       end_seen, end_done, end_err, end_busy;
  logic [1:0] end_code, end_oe, end_pads;
  int         end_cyc;
  logic       rx_ok, rx_start, rx_par, rx_stop;
  logic [7:0] rx_byte;
  int         rx_rel_cyc;

  task automatic send_start(input logic [7:0] b);
    @(negedge clk);
    host_if.tx_data = b;
    host_if.tx_start = 1'b1;
    @(negedge clk);
    host_if.tx_start = 1'b0;
    busy_after_start = host_if.busy;
  endtask

  task automatic wait_end(input int bound);
    int n;
    n = 0;
    end_seen = 1'b0;
    while (!end_seen && n < bound) begin
      @(negedge clk);
      n++;
      if (host_if.tx_done || host_if.tx_err) begin
        end_seen = 1'b1;
        end_done = host_if.tx_done;
        end_err  = host_if.tx_err;
        end_code = host_if.err_code;
        end_busy = host_if.busy;
        end_oe   = {ps2clk_oe, ps2data_oe};
        end_pads = {ps2clk_in, ps2data_in};
        end_cyc  = cyc;
      end
    end
    chk("end_seen", 32'(end_seen), 1);
  endtask

  task automatic dev_clock(output logic s);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    s = ps2data_in;
    dev_clk_low = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // Device model: waits for the start bit, clocks nclk bits (max 10),
  // then optionally the ACK clock.
  task automatic dev_receive(input logic do_ack, input logic glitch, input int nclk);
    int n;
    logic s;
    n = 0;
    rx_ok = 1'b0;
    while (!(ps2data_in == 1'b0 && ps2clk_oe == 1'b0) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) return;
    rx_ok = 1'b1;
    rx_start = ps2data_in;
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= 10 && k <= nclk; k++) begin
      dev_clock(s);
      if (k <= 8) rx_byte[k-1] = s;
      else if (k == 9) rx_par = s;
      else rx_stop = s;
      if (glitch && k == 3) begin
        dev_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
      end
    end
    if (nclk < 11) return;
    dev_data_low = do_ack;
    repeat (HALF / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    rx_rel_cyc = cyc;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic do_xfer(input logic [7:0] b, input logic do_ack, input logic glitch,
                         input logic mid_start);
    send_start(b);
    chk("busy_rise", 32'(busy_after_start), 1);
    fork
      dev_receive(do_ack, glitch, 11);
      wait_end(BOUND);
      if (mid_start) begin
        repeat (INH + 300) @(negedge clk);
        host_if.tx_data = 8'h55;
        host_if.tx_start = 1'b1;
        @(negedge clk);
        host_if.tx_start = 1'b0;
      end
    join
    chk("dev_saw_start", 32'(rx_ok), 1);
  endtask

  logic [7:0] par_vec [3] = '{8'h00, 8'hFF, 8'h01};
  logic       par_exp [3] = '{1'b1, 1'b1, 1'b0};
  int         d0, e0;

  initial begin
    host_if.tx_data = 8'h00;
    host_if.tx_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", 32'(ps2clk_oe), 0);
    chk("rst_data_oe", 32'(ps2data_oe), 0);
    chk("rst_busy", 32'(host_if.busy), 0);
    chk("rst_done_err", 32'({host_if.tx_done, host_if.tx_err}), 0);
    chk("rst_code", 32'(host_if.err_code), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Happy path 0xED
    d0 = done_cnt;
    do_xfer(8'hED, 1'b1, 1'b0, 1'b0);
    chk("inhibit_len", 32'(last_inh), INH);
    chk("ed_start_bit", 32'(rx_start), 0);
    chk("ed_byte", 32'(rx_byte), 32'hED);
    chk("ed_parity", 32'(rx_par), 1);
    chk("ed_stop", 32'(rx_stop), 1);
    chk("ed_done", 32'({end_done, end_err}), 32'b10);
    chk("ed_code", 32'(end_code), 0);
    repeat (20) @(negedge clk);
    chk("ed_busy_after", 32'(host_if.busy), 0);
    chk("ed_done_once", 32'(done_cnt - d0), 1);

    // Parity cases
    for (int i = 0; i < 3; i++) begin
      do_xfer(par_vec[i], 1'b1, 1'b0, 1'b0);
      chk("par_byte", 32'(rx_byte), 32'(par_vec[i]));
      chk("par_bit", 32'(rx_par), 32'(par_exp[i]));
      chk("par_done", 32'(end_done), 1);
    end

    // No ACK
    d0 = done_cnt;
    e0 = err_cnt;
    do_xfer(8'hF4, 1'b0, 1'b0, 1'b0);
    chk("noack_flags", 32'({end_done, end_err}), 32'b01);
    chk("noack_code", 32'(end_code), 32'b10);
    chk("noack_after_release", 32'(end_cyc > rx_rel_cyc), 1);
    chk("noack_lines_high", 32'(end_pads), 32'b11);
    repeat (20) @(negedge clk);
    chk("noack_no_done", 32'(done_cnt - d0), 0);
    chk("noack_err_once", 32'(err_cnt - e0), 1);

    // Ignored mid-transfer start plus clock glitch
    do_xfer(8'hED, 1'b1, 1'b1, 1'b1);
    chk("robust_byte", 32'(rx_byte), 32'hED);
    chk("robust_parity", 32'(rx_par), 1);
    chk("robust_done", 32'({end_done, end_err}), 32'b10);
    chk("robust_code", 32'(end_code), 0);

    // Reset after 4 bits of 0x00
    send_start(8'h00);
    dev_receive(1'b1, 1'b0, 4);
    chk("rst_mid_pre_doe", 32'(ps2data_oe), 1);
    chk("rst_mid_pre_busy", 32'(host_if.busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_oe", 32'({ps2clk_oe, ps2data_oe}), 0);
    chk("rst_mid_busy", 32'(host_if.busy), 0);
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_xfer(8'hF4, 1'b1, 1'b0, 1'b0);
    chk("f4_byte", 32'(rx_byte), 32'hF4);
    chk("f4_parity", 32'(rx_par), 0);
    chk("f4_done", 32'({end_done, end_err}), 32'b10);

    // Timeout: device never clocks
    d0 = done_cnt;
    send_start(8'hED);
    wait_end(INH + TO + 1000);
    chk("to_flags", 32'({end_done, end_err}), 32'b01);
    chk("to_code", 32'(end_code), 32'b01);
    chk("to_cycles", 32'(end_cyc - start_cyc), TO);
    chk("to_oe", 32'(end_oe), 0);
    chk("to_busy", 32'(end_busy), 0);
    repeat (20) @(negedge clk);
    chk("to_no_done", 32'(done_cnt - d0), 0);
    chk("never_both", 32'(both_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
